// File: rtl/wb_pkg.sv
// Shared types for the load writeback stage: load funct3 codes, pending-load
// descriptor and writeback source tag.
package wb_pkg;

    // Descriptor rd field width; matches the default register index width.
    localparam int WB_RD_W = 5;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct packed {
        logic [WB_RD_W-1:0] rd;
        logic [2:0]         funct3;
        logic [1:0]         addr_lo;
    } ld_desc_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_LD,
        WB_ALU
    } wb_src_e;

endpackage

// File: rtl/load_writeback_fifo.sv
// load_pending_fifo: DEPTH-entry FIFO of outstanding load descriptors, kept in
// issue order so in-order memory responses can be matched to their destination.
module load_pending_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  ld_desc_t push_desc,
    input  logic     pop,
    output ld_desc_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0] wr_ptr, rd_ptr;
    ld_desc_t       mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head  = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[PTR_W-1:0]] <= push_desc;
    end

endmodule

// File: rtl/load_writeback.sv
// Writeback stage: merges ALU results with in-order load responses, aligns load
// data and tracks busy registers. Define WB_TRACE_EN for a per-write trace.
module load_writeback
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_RD_W,
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_issue_valid,
    output logic                  ld_issue_ready,
    input  logic [ADDR_WIDTH-1:0] ld_issue_rd,
    input  logic [2:0]            ld_funct3,
    input  logic [1:0]            ld_addr_lo,
    input  logic                  mem_rsp_valid,
    input  logic [WIDTH-1:0]      mem_rsp_data,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [WIDTH-1:0]      alu_wd,
    input  logic [ADDR_WIDTH-1:0] chk_rs1,
    input  logic [ADDR_WIDTH-1:0] chk_rs2,
    output logic                  hazard,
    output logic [ADDR_WIDTH-1:0] rd,
    output logic [WIDTH-1:0]      rd_wd,
    output logic                  rd_we
);

    function automatic logic [WIDTH-1:0] align_load(input logic [WIDTH-1:0] word,
                                                    input logic [2:0]       f3,
                                                    input logic [1:0]       lo);
        logic signed [7:0]       b;
        logic signed [15:0]      h;
        logic signed [WIDTH-1:0] ext;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (f3)
            LB:      ext = b;
            LH:      ext = h;
            LBU:     ext = {{(WIDTH-8){1'b0}}, b};
            LHU:     ext = {{(WIDTH-16){1'b0}}, h};
            LW:      ext = word;
            default: ext = word;
        endcase
        return ext;
    endfunction

    ld_desc_t                   issue_desc, head_desc;
    logic                       fifo_full, fifo_empty;
    logic                       issue_fire, rsp_fire, alu_fire;
    logic [2**ADDR_WIDTH-1:0]   busy;
    wb_src_e                    wb_src_p1;
    logic [WIDTH-1:0]           ld_wd_p0;

    assign ld_issue_ready = !fifo_full && !(ld_issue_rd != '0 && busy[ld_issue_rd]);
    assign issue_fire     = ld_issue_valid && ld_issue_ready;
    // Responses arriving with nothing outstanding are dropped.
    assign rsp_fire       = mem_rsp_valid && !fifo_empty;
    assign alu_ready      = !rsp_fire;
    assign alu_fire       = alu_valid && alu_ready;
    assign hazard         = (chk_rs1 != '0 && busy[chk_rs1]) ||
                            (chk_rs2 != '0 && busy[chk_rs2]);

    assign issue_desc = '{rd: ld_issue_rd, funct3: ld_funct3, addr_lo: ld_addr_lo};
    assign ld_wd_p0   = align_load(mem_rsp_data, head_desc.funct3, head_desc.addr_lo);

    load_pending_fifo #(.DEPTH(DEPTH)) u_pending (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (issue_fire),
        .push_desc (issue_desc),
        .pop       (rsp_fire),
        .head      (head_desc),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // p0 -> p1: arbitrated register-file write, load response has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd        <= '0;
            rd_wd     <= '0;
            rd_we     <= 1'b0;
            wb_src_p1 <= WB_NONE;
        end else if (rsp_fire) begin
            rd        <= head_desc.rd;
            rd_wd     <= ld_wd_p0;
            rd_we     <= (head_desc.rd != '0);
            wb_src_p1 <= WB_LD;
        end else if (alu_fire) begin
            rd        <= alu_rd;
            rd_wd     <= alu_wd;
            rd_we     <= (alu_rd != '0);
            wb_src_p1 <= WB_ALU;
        end else begin
            rd_we     <= 1'b0;
            wb_src_p1 <= WB_NONE;
        end
    end

    // Busy drops only after the load write has been presented to the regfile,
    // so decode keeps stalling until the value is actually readable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            if (rd_we && wb_src_p1 == WB_LD)
                busy[rd] <= 1'b0;
            if (issue_fire && ld_issue_rd != '0)
                busy[ld_issue_rd] <= 1'b1;
        end
    end

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst_n && rd_we)
            $display("%0t WB %s rd=%0d rd_wd=0x%h", $time,
                     (wb_src_p1 == WB_LD) ? "LD" : "ALU", rd, rd_wd);
        if (rst_n && mem_rsp_valid && fifo_empty)
            $display("%0t WB warning: load response with no pending load ignored", $time);
    end
`else
`endif

endmodule

// File: tb/tb_load_writeback.sv
// Randomized bench for load_writeback with a queue-based reference model and a
// write scoreboard checked by an independent monitor.
module tb_load_writeback;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        ld_issue_valid;
    logic        ld_issue_ready;
    logic [4:0]  ld_issue_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        hazard;
    logic [4:0]  rd;
    logic [31:0] rd_wd;
    logic        rd_we;

    load_writeback #(.ADDR_WIDTH(5), .WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_ready (ld_issue_ready),
        .ld_issue_rd    (ld_issue_rd),
        .ld_funct3      (ld_funct3),
        .ld_addr_lo     (ld_addr_lo),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_wd         (alu_wd),
        .chk_rs1        (chk_rs1),
        .chk_rs2        (chk_rs2),
        .hazard         (hazard),
        .rd             (rd),
        .rd_wd          (rd_wd),
        .rd_we          (rd_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int rd; int f3; int lo; } pdesc_t;
    typedef struct { int rd; logic [31:0] wd; int cyc; } wr_t;

    pdesc_t pend[$];
    wr_t    exp_q[$];
    bit     busy_m[32];
    int     clr_now = -1;
    int     clr_next = -1;
    bit     alu_taken = 1'b1;
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    // Load result from the RV32I rules: shift the addressed lane down, mask, sign-fix.
    function automatic logic [31:0] model_load(input logic [31:0] w, input int f3, input int lo);
        logic [31:0] v;
        case (f3)
            0: begin v = (w >> (8 * lo)) & 32'hFF;          if (v >= 32'h80)   v = v - 32'h100;   end
            1: begin v = (w >> (16 * (lo / 2))) & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
            4: v = (w >> (8 * lo)) & 32'hFF;
            5: v = (w >> (16 * (lo / 2))) & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    // Monitor: every register-file write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rd_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual rd=%0d wd=0x%h expected no write", rd, rd_wd);
                end else begin
                    e = exp_q.pop_front();
                    check("wb_rd", 32'(rd), 32'(e.rd));
                    check("wb_wd", rd_wd, e.wd);
                    check("wb_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic step(input bit iv, input int ird, input int f3, input int lo,
                        input bit rv, input logic [31:0] rdat,
                        input bit av, input int ard, input logic [31:0] awd,
                        input int rs1, input int rs2);
        bit     exp_ir, exp_hz, rsp_acc;
        pdesc_t d;
        logic [4:0] t_rd, t_ard, t_rs1, t_rs2;
        logic [2:0] t_f3;
        logic [1:0] t_lo;
        t_rd = ird[4:0]; t_ard = ard[4:0]; t_rs1 = rs1[4:0]; t_rs2 = rs2[4:0];
        t_f3 = f3[2:0];  t_lo = lo[1:0];
        ld_issue_valid = iv;  ld_issue_rd = t_rd; ld_funct3 = t_f3; ld_addr_lo = t_lo;
        mem_rsp_valid  = rv;  mem_rsp_data = rdat;
        alu_valid      = av;  alu_rd = t_ard;     alu_wd = awd;
        chk_rs1        = t_rs1; chk_rs2 = t_rs2;
        #1;
        exp_ir  = (pend.size() < DEPTH) && !(ird != 0 && busy_m[ird]);
        rsp_acc = rv && (pend.size() > 0);
        exp_hz  = (rs1 != 0 && busy_m[rs1]) || (rs2 != 0 && busy_m[rs2]);
        check("ld_issue_ready", 32'(ld_issue_ready), 32'(exp_ir));
        check("alu_ready", 32'(alu_ready), 32'(!rsp_acc));
        check("hazard", 32'(hazard), 32'(exp_hz));
        if (rsp_acc) begin
            d = pend.pop_front();
            if (d.rd != 0) begin
                exp_q.push_back('{d.rd, model_load(rdat, d.f3, d.lo), cyc + 1});
                clr_next = d.rd;
            end
        end else if (av && ard != 0) begin
            exp_q.push_back('{ard, awd, cyc + 1});
        end
        alu_taken = av && !rsp_acc;
        if (iv && exp_ir) begin
            pend.push_back('{ird, f3, lo});
            if (ird != 0) busy_m[ird] = 1'b1;
        end
        @(posedge clk);
        #1;
        if (clr_now >= 0) busy_m[clr_now] = 1'b0;
        clr_now  = clr_next;
        clr_next = -1;
    endtask

    task automatic idle(input int rs1);
        step(0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, rs1, 0);
    endtask

    task automatic do_reset(input int rs1);
        ld_issue_valid = 0; mem_rsp_valid = 0; alu_valid = 0;
        ld_issue_rd = '0; ld_funct3 = '0; ld_addr_lo = '0; mem_rsp_data = '0;
        alu_rd = '0; alu_wd = '0; chk_rs1 = rs1[4:0]; chk_rs2 = '0;
        rst_n = 1'b0;
        #2;
        check("rst_rd", 32'(rd), 32'h0);
        check("rst_rd_wd", rd_wd, 32'h0);
        check("rst_rd_we", 32'(rd_we), 32'h0);
        check("rst_ld_issue_ready", 32'(ld_issue_ready), 32'h1);
        check("rst_alu_ready", 32'(alu_ready), 32'h1);
        check("rst_hazard", 32'(hazard), 32'h0);
        pend.delete();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        clr_now = -1; clr_next = -1; alu_taken = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit          a_v;
        int          a_rd;
        logic [31:0] a_wd;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset(0);

        // LB, sign-extended top byte
        step(1, 5, 0, 3, 0, 32'h0, 0, 0, 32'h0, 5, 0);
        step(0, 0, 0, 0, 1, 32'h80FF_1234, 0, 0, 32'h0, 5, 0);
        check("lb_we", 32'(rd_we), 32'h1);
        check("lb_rd", 32'(rd), 32'd5);
        check("lb_wd", rd_wd, 32'hFFFF_FF80);
        idle(5);
        // LHU, upper half
        step(1, 6, 5, 2, 0, 32'h0, 0, 0, 32'h0, 0, 6);
        step(0, 0, 0, 0, 1, 32'h8001_0000, 0, 0, 32'h0, 0, 6);
        check("lhu_wd", rd_wd, 32'h0000_8001);
        idle(0);
        // Load response and ALU in the same cycle, ALU held one cycle
        step(1, 8, 2, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1, 3, 32'h55, 0, 0);
        check("collide_ld_rd", 32'(rd), 32'd8);
        step(0, 0, 0, 0, 0, 32'h0, 1, 3, 32'h55, 0, 0);
        check("collide_alu_rd", 32'(rd), 32'd3);
        check("collide_alu_wd", rd_wd, 32'h55);
        idle(0);
        // Hazard lifetime on x7 and blocked re-issue
        step(1, 7, 2, 0, 0, 32'h0, 0, 0, 32'h0, 7, 0);
        idle(7);
        step(1, 7, 2, 0, 0, 32'h0, 0, 0, 32'h0, 7, 0);
        step(0, 0, 0, 0, 1, 32'h0000_0777, 0, 0, 32'h0, 7, 0);
        idle(7);
        check("hazard_cleared", 32'(hazard), 32'h0);
        idle(7);
        // FIFO full: stalls even with a same-cycle pop
        for (int r = 1; r <= 4; r++) step(1, r, 2, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        step(1, 9, 2, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        step(1, 9, 2, 0, 1, 32'h1111_0001, 0, 0, 32'h0, 0, 0);
        check("full_ready_again", 32'(ld_issue_ready), 32'h1);
        for (int r = 0; r < 3; r++) step(0, 0, 0, 0, 1, $urandom, 0, 0, 32'h0, 0, 0);
        idle(0);
        idle(0);
        // Reset with loads outstanding, then a stale response
        step(1, 10, 2, 0, 0, 32'h0, 0, 0, 32'h0, 10, 0);
        step(1, 11, 2, 0, 0, 32'h0, 0, 0, 32'h0, 10, 11);
        idle(10);
        do_reset(10);
        step(0, 0, 0, 0, 1, 32'hCAFE_F00D, 0, 0, 32'h0, 10, 11);
        check("stale_rsp_no_write", 32'(rd_we), 32'h0);
        idle(10);
        // Load to x0 never writes
        step(1, 0, 2, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h1234_5678, 0, 0, 32'h0, 0, 0);
        check("x0_load_no_write", 32'(rd_we), 32'h0);
        idle(0);

        // Random traffic; ALU request is held until accepted
        a_v = 0; a_rd = 0; a_wd = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(a_v && !alu_taken)) begin
                a_v  = ($urandom_range(0, 2) == 0);
                a_rd = $urandom_range(0, 31);
                a_wd = $urandom;
            end
            step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 3), ($urandom_range(0, 4) < 2), $urandom,
                 a_v, a_rd, a_wd, $urandom_range(0, 7), $urandom_range(0, 7));
        end
        if (a_v && !alu_taken) step(0, 0, 0, 0, 0, 32'h0, 1, a_rd, a_wd, 0, 0);
        for (int k = 0; k < 20 && pend.size() > 0; k++)
            step(0, 0, 0, 0, 1, $urandom, 0, 0, 32'h0, 0, 0);
        idle(0);
        idle(0);
        idle(0);
        check("writes_outstanding", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
